imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 9 +
 rtl/loader_byte_packer.sv | 25 ++
 rtl/imem_loader.sv | 139 +++++++++++++
 tb/tb_imem_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared state encoding and constants for the instruction-memory loader
package imem_loader_pkg;
   typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, CHECK, DONE, ERR} state_e;
   localparam logic [7:0] HEADER_DEF  = 8'hA5;
   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_COUNT   = 2'b01;
   localparam logic [1:0] ERR_CSUM    = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/loader_byte_packer.sv
// loader_byte_packer: assembles four little-endian bytes into a 32-bit word
module loader_byte_packer (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear_i,
   input  logic        en_i,
   input  logic [7:0]  byte_i,
   output logic        word_valid_o,
   output logic [31:0] word_o
);
   logic [1:0]  idx_q;
   logic [23:0] lo_q;
   assign word_valid_o = en_i & (idx_q == 2'd3);
   assign word_o       = {byte_i, lo_q};
   // Shift bytes in from the top so the first byte ends up in the lowest lane
   always_ff @(posedge clk) begin
      if (!rst_n || clear_i) begin
         idx_q <= '0;
         lo_q  <= '0;
      end else if (en_i) begin
         idx_q <= idx_q + 1'b1;
         lo_q  <= {byte_i, lo_q[23:8]};
      end
   end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte stream to instruction memory, releasing the core on a good checksum
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int         ADDR_W      = 10,
   parameter int         TIMEOUT_CYC = 1000000,
   parameter logic [7:0] HEADER      = HEADER_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        in_data_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   output logic              imem_we_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   output logic [31:0]       imem_wdata_o,
   output logic              cpu_hold_o,
   output logic              done_o,
   output logic              error_o,
   output logic [1:0]        err_code_o
);
   localparam logic [16:0]   DEPTH  = 17'(1 << ADDR_W);
   localparam int            TW     = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
   state_e            state_q;
   logic [7:0]        cnt_lo_q;
   logic [7:0]        chk_q;
   logic [15:0]       n_q;
   logic [ADDR_W-1:0] widx_q;
   logic [TW-1:0]     timer_q;
   logic [TW-1:0]     timer_d;
   logic              acc;
   logic              is_hdr;
   logic              hdr_start;
   logic              timer_run;
   logic              expire;
   logic              word_valid;
   logic [31:0]       word;
   logic [16:0]       n_in;
   assign acc       = in_valid_i & in_ready_o;
   assign is_hdr    = in_data_i == HEADER;
   assign hdr_start = acc & is_hdr & (state_q inside {IDLE, DONE, ERR});
   assign n_in      = {1'b0, in_data_i, cnt_lo_q};
   assign timer_run = state_q inside {CNT_LO, CNT_HI, DATA, CHECK};
   assign timer_d   = (acc || !timer_run) ? '0 : timer_q + 1'b1;
   // An accepted byte in the expiry cycle takes priority over the timeout
   assign expire    = timer_run & !acc & (timer_q == T_LAST);

   loader_byte_packer u_packer (
      .clk          (clk),
      .rst_n        (rst_n),
      .clear_i      (hdr_start),
      .en_i         (acc && state_q == DATA),
      .byte_i       (in_data_i),
      .word_valid_o (word_valid),
      .word_o       (word)
   );

   // Frame sequencer: header/count parsing, word writes, checksum verdict and timeout abort
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cnt_lo_q     <= '0;
         n_q          <= '0;
         widx_q       <= '0;
         chk_q        <= '0;
         timer_q      <= '0;
         in_ready_o   <= 1'b1;
         imem_we_o    <= 1'b0;
         imem_addr_o  <= '0;
         imem_wdata_o <= '0;
         cpu_hold_o   <= 1'b1;
         done_o       <= 1'b0;
         error_o      <= 1'b0;
         err_code_o   <= ERR_NONE;
      end else begin
         timer_q    <= timer_d;
         imem_we_o  <= word_valid;
         in_ready_o <= !word_valid;
         if (expire) begin
            state_q    <= ERR;
            error_o    <= 1'b1;
            err_code_o <= ERR_TIMEOUT;
         end else if (acc) begin
            case (state_q)
               IDLE, DONE, ERR: begin
                  if (is_hdr) begin
                     state_q     <= CNT_LO;
                     chk_q       <= '0;
                     widx_q      <= '0;
                     imem_addr_o <= '0;
                     cpu_hold_o  <= 1'b1;
                     done_o      <= 1'b0;
                     error_o     <= 1'b0;
                     err_code_o  <= ERR_NONE;
                  end
               end
               CNT_LO: begin
                  cnt_lo_q <= in_data_i;
                  state_q  <= CNT_HI;
               end
               CNT_HI: begin
                  n_q    <= n_in[15:0];
                  widx_q <= '0;
                  if (n_in > DEPTH) begin
                     state_q    <= ERR;
                     error_o    <= 1'b1;
                     err_code_o <= ERR_COUNT;
                  end else begin
                     state_q <= (n_in == '0) ? CHECK : DATA;
                  end
               end
               DATA: begin
                  chk_q <= chk_q ^ in_data_i;
                  if (word_valid) begin
                     imem_addr_o  <= widx_q;
                     imem_wdata_o <= word;
                     widx_q       <= widx_q + 1'b1;
                     if (17'(widx_q) + 17'd1 == {1'b0, n_q})
                        state_q <= CHECK;
                  end
               end
               CHECK: begin
                  if (in_data_i == chk_q) begin
                     state_q    <= DONE;
                     done_o     <= 1'b1;
                     cpu_hold_o <= 1'b0;
                  end else begin
                     state_q    <= ERR;
                     error_o    <= 1'b1;
                     err_code_o <= ERR_CSUM;
                  end
               end
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized frame stimulus checked against a frame-level reference model
module tb_imem_loader;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  in_data_i = '0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic        imem_we_o;
   logic [9:0]  imem_addr_o;
   logic [31:0] imem_wdata_o;
   logic        cpu_hold_o;
   logic        done_o;
   logic        error_o;
   logic [1:0]  err_code_o;

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   int          acc_cyc[$];
   logic [7:0]  acc_dat[$];
   int          nr_cyc[$];
   logic [9:0]  wr_addr[$];
   logic [31:0] wr_data[$];
   logic [7:0]  frame[$];
   logic [31:0] exp_w[$];

   imem_loader #(.ADDR_W(10), .TIMEOUT_CYC(100), .HEADER(8'hA5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_data_i    (in_data_i),
      .in_valid_i   (in_valid_i),
      .in_ready_o   (in_ready_o),
      .imem_we_o    (imem_we_o),
      .imem_addr_o  (imem_addr_o),
      .imem_wdata_o (imem_wdata_o),
      .cpu_hold_o   (cpu_hold_o),
      .done_o       (done_o),
      .error_o      (error_o),
      .err_code_o   (err_code_o)
   );

   always #5 clk = ~clk;

   // Observe handshakes, stalls and memory writes mid-cycle
   always @(negedge clk) begin
      cyc++;
      if (in_valid_i && in_ready_o) begin
         acc_cyc.push_back(cyc);
         acc_dat.push_back(in_data_i);
      end
      if (!in_ready_o) nr_cyc.push_back(cyc);
      if (imem_we_o) begin
         wr_addr.push_back(imem_addr_o);
         wr_data.push_back(imem_wdata_o);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   task automatic clear_log();
      acc_cyc = {};
      acc_dat = {};
      nr_cyc = {};
      wr_addr = {};
      wr_data = {};
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      in_valid_i = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_log();
   endtask

   // Present bytes in order, holding each until accepted; returns one step after the last accept edge
   task automatic drive(input logic [7:0] b[$], input int gap_pct);
      int i = 0;
      int guard = 0;
      while (i < b.size()) begin
         @(posedge clk); #1;
         if (gap_pct > 0 && $urandom_range(99) < gap_pct) in_valid_i = 1'b0;
         else begin
            in_valid_i = 1'b1;
            in_data_i = b[i];
         end
         @(negedge clk);
         if (in_valid_i && in_ready_o) i++;
         if (++guard > 20000) begin
            tests++;
            fails++;
            $display("FAIL drive.stuck got=%0d bytes exp=%0d", i, b.size());
            break;
         end
      end
      @(posedge clk); #1;
      in_valid_i = 1'b0;
   endtask

   // Reference frame: random words, checksum folded from the XOR of whole words
   task automatic make_frame(input int n, input bit good);
      logic [31:0] x = '0;
      logic [31:0] w;
      logic [7:0]  c;
      frame = {};
      exp_w = {};
      frame.push_back(8'hA5);
      frame.push_back(n[7:0]);
      frame.push_back(n[15:8]);
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         exp_w.push_back(w);
         x ^= w;
         for (int k = 0; k < 4; k++) frame.push_back(w[8*k +: 8]);
      end
      c = x[7:0] ^ x[15:8] ^ x[23:16] ^ x[31:24];
      if (!good) c ^= 8'($urandom_range(1, 255));
      frame.push_back(c);
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (imem_we_o !== 1'b0) begin fails++; $display("FAIL reset.we got=%0b exp=0", imem_we_o); end
      tests++; if (imem_addr_o !== 10'd0) begin fails++; $display("FAIL reset.addr got=%0h exp=0", imem_addr_o); end
      tests++; if (imem_wdata_o !== 32'd0) begin fails++; $display("FAIL reset.wdata got=%0h exp=0", imem_wdata_o); end
      tests++; if (cpu_hold_o !== 1'b1) begin fails++; $display("FAIL reset.hold got=%0b exp=1", cpu_hold_o); end
      tests++; if (done_o !== 1'b0) begin fails++; $display("FAIL reset.done got=%0b exp=0", done_o); end
      tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL reset.error got=%0b exp=0", error_o); end
      tests++; if (err_code_o !== 2'b00) begin fails++; $display("FAIL reset.err_code got=%0b exp=00", err_code_o); end
      tests++; if (in_ready_o !== 1'b1) begin fails++; $display("FAIL reset.ready got=%0b exp=1", in_ready_o); end
   endtask

   task automatic test_frame_ok();
      logic [7:0] f[$];
      f = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00};
      drive(f, 0);
      repeat (3) @(posedge clk); #1;
      tests++; if (done_o !== 1'b0 || cpu_hold_o !== 1'b1) begin fails++; $display("FAIL frame_ok.pre done=%0b hold=%0b exp done=0 hold=1", done_o, cpu_hold_o); end
      f = '{8'hF0};
      drive(f, 0);
      tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL frame_ok.done got=%0b exp=1", done_o); end
      tests++; if (cpu_hold_o !== 1'b0) begin fails++; $display("FAIL frame_ok.hold got=%0b exp=0", cpu_hold_o); end
      tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL frame_ok.nwrites got=%0d exp=2", wr_addr.size()); end
      else begin
         tests++; if (wr_addr[0] !== 10'd0 || wr_data[0] !== 32'h00000013) begin fails++; $display("FAIL frame_ok.w0 got=%0h:%h exp=0:00000013", wr_addr[0], wr_data[0]); end
         tests++; if (wr_addr[1] !== 10'd1 || wr_data[1] !== 32'h005000B3) begin fails++; $display("FAIL frame_ok.w1 got=%0h:%h exp=1:005000b3", wr_addr[1], wr_data[1]); end
      end
   endtask

   task automatic test_bad_chk();
      logic [7:0] f[$];
      clear_log();
      f = '{8'hA5};
      drive(f, 0);
      tests++; if (cpu_hold_o !== 1'b1 || done_o !== 1'b0) begin fails++; $display("FAIL bad_chk.restart hold=%0b done=%0b exp hold=1 done=0", cpu_hold_o, done_o); end
      f = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB3, 8'h00, 8'h50, 8'h00, 8'h00};
      drive(f, 0);
      tests++; if (error_o !== 1'b1 || err_code_o !== 2'b10) begin fails++; $display("FAIL bad_chk.err got=%0b/%0b exp=1/10", error_o, err_code_o); end
      tests++; if (cpu_hold_o !== 1'b1 || done_o !== 1'b0) begin fails++; $display("FAIL bad_chk.hold hold=%0b done=%0b exp hold=1 done=0", cpu_hold_o, done_o); end
      tests++; if (wr_addr.size() !== 2) begin fails++; $display("FAIL bad_chk.nwrites got=%0d exp=2", wr_addr.size()); end
   endtask

   task automatic test_count_overflow();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'hFF, 8'hFF};
      drive(f, 0);
      tests++; if (error_o !== 1'b1 || err_code_o !== 2'b01) begin fails++; $display("FAIL count_ovf.err got=%0b/%0b exp=1/01", error_o, err_code_o); end
      tests++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL count_ovf.nwrites got=%0d exp=0", wr_addr.size()); end
      f = '{8'hA5};
      drive(f, 0);
      tests++; if (error_o !== 1'b0 || err_code_o !== 2'b00) begin fails++; $display("FAIL count_ovf.clear got=%0b/%0b exp=0/00", error_o, err_code_o); end
      do_reset();
      f = '{8'hA5, 8'h01, 8'h04};
      drive(f, 0);
      tests++; if (error_o !== 1'b1 || err_code_o !== 2'b01) begin fails++; $display("FAIL count_1025.err got=%0b/%0b exp=1/01", error_o, err_code_o); end
   endtask

   task automatic test_timeout();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'h01, 8'h00, 8'h11};
      drive(f, 0);
      repeat (99) @(posedge clk);
      #1;
      in_valid_i = 1'b1;
      in_data_i = 8'h22;
      @(posedge clk); #1;
      in_valid_i = 1'b0;
      tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL timeout.byte_wins error got=%0b exp=0", error_o); end
      repeat (99) @(posedge clk);
      #1;
      tests++; if (error_o !== 1'b0) begin fails++; $display("FAIL timeout.early error got=%0b exp=0 at cycle 99", error_o); end
      @(posedge clk); #1;
      tests++; if (error_o !== 1'b1 || err_code_o !== 2'b11) begin fails++; $display("FAIL timeout.fire got=%0b/%0b exp=1/11", error_o, err_code_o); end
      tests++; if (wr_addr.size() !== 0 || cpu_hold_o !== 1'b1) begin fails++; $display("FAIL timeout.state writes=%0d hold=%0b exp writes=0 hold=1", wr_addr.size(), cpu_hold_o); end
   endtask

   task automatic test_back_to_back();
      int bad = 0;
      do_reset();
      make_frame(3, 1'b1);
      drive(frame, 0);
      tests++; if (acc_dat.size() !== frame.size()) begin fails++; $display("FAIL b2b.nbytes got=%0d exp=%0d", acc_dat.size(), frame.size()); end
      else begin
         for (int i = 0; i < frame.size(); i++) if (acc_dat[i] !== frame[i]) bad++;
         tests++; if (bad != 0) begin fails++; $display("FAIL b2b.bytes got=%0d mismatched exp=0", bad); end
         tests++; if (nr_cyc.size() !== 3) begin fails++; $display("FAIL b2b.nstalls got=%0d exp=3", nr_cyc.size()); end
         else for (int j = 0; j < 3; j++) begin
            tests++; if (nr_cyc[j] !== acc_cyc[6 + 4*j] + 1) begin fails++; $display("FAIL b2b.stall%0d got=%0d exp=%0d", j, nr_cyc[j], acc_cyc[6 + 4*j] + 1); end
         end
      end
      tests++; if (wr_addr.size() !== 3) begin fails++; $display("FAIL b2b.nwrites got=%0d exp=3", wr_addr.size()); end
      else for (int j = 0; j < 3; j++) begin
         tests++; if (wr_addr[j] !== 10'(j) || wr_data[j] !== exp_w[j]) begin fails++; $display("FAIL b2b.w%0d got=%0h:%h exp=%0h:%h", j, wr_addr[j], wr_data[j], j, exp_w[j]); end
      end
      tests++; if (done_o !== 1'b1) begin fails++; $display("FAIL b2b.done got=%0b exp=1", done_o); end
   endtask

   task automatic test_reset_mid();
      logic [7:0] f[$];
      do_reset();
      f = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
      drive(f, 0);
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      clear_log();
      tests++; if (cpu_hold_o !== 1'b1 || in_ready_o !== 1'b1 || imem_we_o !== 1'b0) begin fails++; $display("FAIL reset_mid.state hold=%0b ready=%0b we=%0b exp 1/1/0", cpu_hold_o, in_ready_o, imem_we_o); end
      f = '{8'h00, 8'hA5, 8'h00, 8'h00, 8'h00};
      drive(f, 0);
      tests++; if (done_o !== 1'b1 || cpu_hold_o !== 1'b0) begin fails++; $display("FAIL reset_mid.done done=%0b hold=%0b exp done=1 hold=0", done_o, cpu_hold_o); end
      tests++; if (wr_addr.size() !== 0) begin fails++; $display("FAIL reset_mid.nwrites got=%0d exp=0", wr_addr.size()); end
   endtask

   task automatic test_random_frames();
      logic [7:0] g;
      int n;
      bit good;
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(0, 6);
         good = $urandom_range(0, 3) != 0;
         make_frame(n, good);
         if ($urandom_range(1)) begin
            g = 8'($urandom_range(0, 255));
            if (g == 8'hA5) g = 8'h00;
            frame.push_front(g);
         end
         clear_log();
         drive(frame, 30);
         tests++; if (done_o !== good || error_o !== !good || cpu_hold_o !== !good) begin fails++; $display("FAIL rand%0d.status done=%0b err=%0b hold=%0b exp good=%0b", it, done_o, error_o, cpu_hold_o, good); end
         tests++; if (err_code_o !== (good ? 2'b00 : 2'b10)) begin fails++; $display("FAIL rand%0d.err_code got=%0b exp=%0b", it, err_code_o, good ? 2'b00 : 2'b10); end
         tests++; if (wr_addr.size() !== n) begin fails++; $display("FAIL rand%0d.nwrites got=%0d exp=%0d", it, wr_addr.size(), n); end
         else for (int j = 0; j < n; j++) begin
            tests++; if (wr_addr[j] !== 10'(j) || wr_data[j] !== exp_w[j]) begin fails++; $display("FAIL rand%0d.w%0d got=%0h:%h exp=%0h:%h", it, j, wr_addr[j], wr_data[j], j, exp_w[j]); end
         end
      end
   endtask

   task automatic test_full_depth();
      int bad = 0;
      make_frame(1024, 1'b1);
      clear_log();
      drive(frame, 0);
      tests++; if (wr_addr.size() !== 1024) begin fails++; $display("FAIL full.nwrites got=%0d exp=1024", wr_addr.size()); end
      else begin
         for (int j = 0; j < 1024; j++) if (wr_addr[j] !== 10'(j) || wr_data[j] !== exp_w[j]) bad++;
         tests++; if (bad != 0) begin fails++; $display("FAIL full.words got=%0d mismatched exp=0", bad); end
         tests++; if (wr_addr[1023] !== 10'd1023) begin fails++; $display("FAIL full.last_addr got=%0d exp=1023", wr_addr[1023]); end
      end
      tests++; if (done_o !== 1'b1 || error_o !== 1'b0) begin fails++; $display("FAIL full.status done=%0b err=%0b exp 1/0", done_o, error_o); end
   endtask

   initial begin
      test_reset();
      test_frame_ok();
      test_bad_chk();
      test_count_overflow();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      test_random_frames();
      test_full_depth();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
